// File: rtl/gpio_bank_if.sv
// Bus interface for gpio_bank: single-cycle register access from the system bus.
//   address_in     : byte address (only [4:2] decoded by the block)
//   sel_in         : block select from the system address decoder
//   read_in        : read strobe (informational, reads have no side effects)
//   write_mask_in  : byte-lane write enables
//   write_value_in : write data
//   read_value_out : read data, zero when not selected (OR-able onto a shared bus)
//   ready_out      : access complete
interface gpio_bank_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;

   logic [ADDR_W-1:0] address_in;
   logic              sel_in;
   logic              read_in;
   logic [MASK_W-1:0] write_mask_in;
   logic [DATA_W-1:0] write_value_in;
   logic [DATA_W-1:0] read_value_out;
   logic              ready_out;

   modport master (
      output address_in, sel_in, read_in, write_mask_in, write_value_in,
      input  read_value_out, ready_out
   );

   modport slave (
      input  address_in, sel_in, read_in, write_mask_in, write_value_in,
      output read_value_out, ready_out
   );
endinterface

// File: rtl/gpio_bank.sv
// GPIO bank: output/direction registers, synchronized and optionally debounced
// inputs, sticky rise/fall edge flags (write-1-to-clear) and a level interrupt.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : gpio_bank_if slave (register access, combinational ready/read data)
//   pins_in    : asynchronous pad inputs
//   pins_out   : OUT register
//   pins_oe    : DIR register (1 = drive)
//   irq_out    : OR of enabled pending edge flags
module gpio_bank #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 36000
) (
   input  logic             clk,
   input  logic             reset,
   gpio_bank_if.slave       bus,
   input  logic [WIDTH-1:0] pins_in,
   output logic [WIDTH-1:0] pins_out,
   output logic [WIDTH-1:0] pins_oe,
   output logic             irq_out
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [2:0] OFS_OUT  = 3'd0;
   localparam logic [2:0] OFS_DIR  = 3'd1;
   localparam logic [2:0] OFS_IN   = 3'd2;
   localparam logic [2:0] OFS_RISE = 3'd3;
   localparam logic [2:0] OFS_FALL = 3'd4;
   localparam logic [2:0] OFS_IEN  = 3'd5;

   logic [WIDTH-1:0] out_q, dir_q, ien_q, rise_q, fall_q;
   logic [WIDTH-1:0] sync1_q, sync2_q, filt_q, filt_next_c;
   logic [WIDTH-1:0] wen_c, wdat_c;
   logic [WIDTH-1:0] rise_set_c, fall_set_c, rise_clr_c, fall_clr_c;
   logic [2:0]       ofs_c;
   logic [31:0]      rd_c;
   logic             unused_bus_bits;

   // Address bits outside [4:2], unused mask lanes and the read strobe carry no function
   assign unused_bus_bits = ^{bus.read_in, bus.address_in, bus.write_mask_in, bus.write_value_in};

   assign ofs_c  = bus.address_in[4:2];
   assign wdat_c = bus.write_value_in[WIDTH-1:0];

   // Per-bit write enable from the byte lane covering that bit
   always_comb begin
      wen_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         wen_c[i] = bus.sel_in & bus.write_mask_in[i/8];
      end
   end

   assign rise_clr_c = (ofs_c == OFS_RISE) ? (wen_c & wdat_c) : '0;
   assign fall_clr_c = (ofs_c == OFS_FALL) ? (wen_c & wdat_c) : '0;
   assign rise_set_c = filt_next_c & ~filt_q;
   assign fall_set_c = ~filt_next_c & filt_q;

   // Software-visible registers; set events win over same-cycle clears
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q  <= '0;
         dir_q  <= '0;
         ien_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         if (ofs_c == OFS_OUT) out_q <= (out_q & ~wen_c) | (wdat_c & wen_c);
         if (ofs_c == OFS_DIR) dir_q <= (dir_q & ~wen_c) | (wdat_c & wen_c);
         if (ofs_c == OFS_IEN) ien_q <= (ien_q & ~wen_c) | (wdat_c & wen_c);
         rise_q <= (rise_q & ~rise_clr_c) | rise_set_c;
         fall_q <= (fall_q & ~fall_clr_c) | fall_set_c;
      end
   end

   // Two-flop synchronizer and filtered input register
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         filt_q  <= '0;
      end else begin
         sync1_q <= pins_in;
         sync2_q <= sync1_q;
         filt_q  <= filt_next_c;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign filt_next_c = sync2_q;
      end else begin : g_debounce
         logic [CNT_W-1:0] cnt_q;
         logic [WIDTH-1:0] hist0_q, hist1_q, agree_c;
         logic             tick_c;

         assign tick_c  = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
         assign agree_c = ~(sync2_q ^ hist0_q) & ~(sync2_q ^ hist1_q);
         // A pin follows sync2 only once three consecutive tick samples agree
         assign filt_next_c = tick_c ? ((agree_c & sync2_q) | (~agree_c & filt_q)) : filt_q;

         // Sample-tick prescaler and per-pin tick history
         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q   <= '0;
               hist0_q <= '0;
               hist1_q <= '0;
            end else if (tick_c) begin
               cnt_q   <= '0;
               hist0_q <= sync2_q;
               hist1_q <= hist0_q;
            end else begin
               cnt_q   <= cnt_q + CNT_W'(1);
            end
         end
      end
   endgenerate

   // Read mux, zero when not selected
   always_comb begin
      rd_c = '0;
      if (bus.sel_in) begin
         case (ofs_c)
            OFS_OUT:  rd_c = 32'(out_q);
            OFS_DIR:  rd_c = 32'(dir_q);
            OFS_IN:   rd_c = 32'(filt_q);
            OFS_RISE: rd_c = 32'(rise_q);
            OFS_FALL: rd_c = 32'(fall_q);
            OFS_IEN:  rd_c = 32'(ien_q);
            default:  rd_c = '0;
         endcase
      end
   end

   assign bus.read_value_out = rd_c;
   assign bus.ready_out      = bus.sel_in;
   assign pins_out           = out_q;
   assign pins_oe            = dir_q;
   assign irq_out            = |((rise_q | fall_q) & ien_q);

endmodule
